// File: rtl/jvm_fetch_pkg.sv
// Shared JVM front-end definitions: fetch sequencer states, opcode constants
// and the operand-length table used by both the fetch sequencer and the decoder.
package jvm_fetch_pkg;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_OPC   = 3'd1,
        ST_OPND1 = 3'd2,
        ST_OPND2 = 3'd3,
        ST_EMIT  = 3'd4
    } fetch_state_e;

    localparam logic [7:0] BIPUSH   = 8'h10;
    localparam logic [7:0] SIPUSH   = 8'h11;
    localparam logic [7:0] LDC      = 8'h12;
    localparam logic [7:0] ILOAD    = 8'h15;
    localparam logic [7:0] ISTORE   = 8'h36;
    localparam logic [7:0] IINC     = 8'h84;
    localparam logic [7:0] IF_FIRST = 8'h99;
    localparam logic [7:0] GOTO     = 8'hA7;

    // Number of operand bytes following an opcode; the if*/goto block is a contiguous range.
    function automatic logic [1:0] operand_len(input logic [7:0] op);
        logic [1:0] len;
        case (op)
            BIPUSH, LDC, ILOAD, ISTORE: len = 2'd1;
            SIPUSH, IINC:               len = 2'd2;
            default: begin
                if ((op >= IF_FIRST) && (op <= GOTO)) begin
                    len = 2'd2;
                end else begin
                    len = 2'd0;
                end
            end
        endcase
        return len;
    endfunction

endpackage

// File: rtl/bytecode_fetch_ctrl.sv
// Fetch sequencer: loads the byte generator PC, assembles opcode + operands into
// one instruction per decoder handshake, and restarts cleanly on branch redirect.
module bytecode_fetch_ctrl
    import jvm_fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 8,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     pc_reset,
    output logic                     fetch_start,
    input  logic                     fetch_ready,
    input  logic [7:0]               fetch_byte,
    output logic                     fetch_pc_load_n,
    output logic [ADDRESS_WIDTH-1:0] fetch_pc_value,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     insn_valid,
    input  logic                     insn_ready,
    output logic [7:0]               insn_opcode,
    output logic [15:0]              insn_operand,
    output logic [1:0]               insn_len,
    output logic [ADDRESS_WIDTH-1:0] insn_pc
);

    fetch_state_e             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] load_addr_q, load_addr_d;
    logic [ADDRESS_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [7:0]               opcode_q, opcode_d;
    logic [15:0]              operand_q, operand_d;
    logic [1:0]               len_q, len_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic                     consume_s;
    logic                     redirect_s;

    assign fetch_start     = (state_q == ST_OPC) || (state_q == ST_OPND1) || (state_q == ST_OPND2);
    assign fetch_pc_load_n = (state_q != ST_LOAD);
    assign fetch_pc_value  = load_addr_q;
    assign insn_valid      = (state_q == ST_EMIT);
    assign insn_opcode     = opcode_q;
    assign insn_operand    = operand_q;
    assign insn_len        = len_q;
    assign insn_pc         = pc_q;

    // A redirect outranks a byte arriving in the same cycle, so that byte is dropped.
    assign redirect_s = redirect_valid && (state_q != ST_LOAD);
    assign consume_s  = fetch_start && fetch_ready && !redirect_valid;

    // Next-state and instruction assembly.
    always_comb begin
        state_d      = state_q;
        load_addr_d  = load_addr_q;
        fetch_addr_d = fetch_addr_q;
        opcode_d     = opcode_q;
        operand_d    = operand_q;
        len_d        = len_q;
        pc_d         = pc_q;

        case (state_q)
            ST_LOAD: begin
                fetch_addr_d = load_addr_q;
                state_d      = ST_OPC;
            end
            ST_OPC: begin
                if (consume_s) begin
                    opcode_d  = fetch_byte;
                    pc_d      = fetch_addr_q;
                    len_d     = operand_len(fetch_byte);
                    operand_d = 16'h0000;
                    if (operand_len(fetch_byte) == 2'd0) begin
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_OPND1;
                    end
                end else begin
                    state_d = ST_OPC;
                end
            end
            ST_OPND1: begin
                if (consume_s) begin
                    if (len_q == 2'd2) begin
                        operand_d = {fetch_byte, 8'h00};
                        state_d   = ST_OPND2;
                    end else begin
                        operand_d = {8'h00, fetch_byte};
                        state_d   = ST_EMIT;
                    end
                end else begin
                    state_d = ST_OPND1;
                end
            end
            ST_OPND2: begin
                if (consume_s) begin
                    operand_d = {operand_q[15:8], fetch_byte};
                    state_d   = ST_EMIT;
                end else begin
                    state_d = ST_OPND2;
                end
            end
            ST_EMIT: begin
                if (insn_ready) begin
                    state_d = ST_OPC;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        if (consume_s) begin
            fetch_addr_d = fetch_addr_q + ADDRESS_WIDTH'(1);
        end else begin
            fetch_addr_d = fetch_addr_d;
        end

        // An EMIT-cycle handshake still completes; the redirect only steers the next state.
        if (redirect_s) begin
            load_addr_d = redirect_pc;
            state_d     = ST_LOAD;
        end else begin
            load_addr_d = load_addr_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Address and instruction registers.
    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) begin
            load_addr_q  <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            opcode_q     <= 8'h00;
            operand_q    <= 16'h0000;
            len_q        <= 2'd0;
            pc_q         <= '0;
        end else begin
            load_addr_q  <= load_addr_d;
            fetch_addr_q <= fetch_addr_d;
            opcode_q     <= opcode_d;
            operand_q    <= operand_d;
            len_q        <= len_d;
            pc_q         <= pc_d;
        end
    end

endmodule

// File: tb/tb_bytecode_fetch_ctrl.sv
// Directed bench for bytecode_fetch_ctrl with a simple byte-generator memory model.
module tb_bytecode_fetch_ctrl;

    logic        clk;
    logic        pc_reset;
    logic        fetch_start;
    logic        fetch_ready;
    logic [7:0]  fetch_byte;
    logic        fetch_pc_load_n;
    logic [7:0]  fetch_pc_value;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [7:0]  insn_opcode;
    logic [15:0] insn_operand;
    logic [1:0]  insn_len;
    logic [7:0]  insn_pc;

    int n_cmp;
    int n_err;

    logic [7:0] mem [0:255];
    logic [7:0] gen_addr;

    bytecode_fetch_ctrl #(
        .ADDRESS_WIDTH (8),
        .RESET_PC      (8'h10)
    ) dut (
        .clk             (clk),
        .pc_reset        (pc_reset),
        .fetch_start     (fetch_start),
        .fetch_ready     (fetch_ready),
        .fetch_byte      (fetch_byte),
        .fetch_pc_load_n (fetch_pc_load_n),
        .fetch_pc_value  (fetch_pc_value),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .insn_valid      (insn_valid),
        .insn_ready      (insn_ready),
        .insn_opcode     (insn_opcode),
        .insn_operand    (insn_operand),
        .insn_len        (insn_len),
        .insn_pc         (insn_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte generator model: loads on the active-low strobe, advances on each handshake.
    always @(posedge clk) begin
        if (!fetch_pc_load_n) gen_addr <= fetch_pc_value;
        else if (fetch_start && fetch_ready) gen_addr <= gen_addr + 8'd1;
    end
    assign fetch_byte = mem[gen_addr];

    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (insn_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        pc_reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (fetch_pc_load_n !== 1'b0) begin n_err++; $display("FAIL rst_load_n: got %b expected 0", fetch_pc_load_n); end
        n_cmp++; if (fetch_pc_value !== 8'h10) begin n_err++; $display("FAIL rst_pc_value: got %h expected 10", fetch_pc_value); end
        n_cmp++; if (fetch_start !== 1'b0) begin n_err++; $display("FAIL rst_fetch_start: got %b expected 0", fetch_start); end
        n_cmp++; if (insn_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", insn_valid); end
        n_cmp++; if ({insn_opcode, insn_operand, insn_len, insn_pc} !== 34'h0) begin n_err++; $display("FAIL rst_insn: got %h expected 0", {insn_opcode, insn_operand, insn_len, insn_pc}); end
        pc_reset = 1'b1;
        #1;
        n_cmp++; if (fetch_pc_load_n !== 1'b0) begin n_err++; $display("FAIL load_cycle_load_n: got %b expected 0", fetch_pc_load_n); end
        n_cmp++; if (fetch_pc_value !== 8'h10) begin n_err++; $display("FAIL load_cycle_value: got %h expected 10", fetch_pc_value); end
        @(negedge clk);
        n_cmp++; if (fetch_pc_load_n !== 1'b1) begin n_err++; $display("FAIL post_load_load_n: got %b expected 1", fetch_pc_load_n); end
        n_cmp++; if (fetch_start !== 1'b1) begin n_err++; $display("FAIL post_load_start: got %b expected 1", fetch_start); end
        n_cmp++; if (insn_valid !== 1'b0) begin n_err++; $display("FAIL post_load_valid: got %b expected 0", insn_valid); end
    endtask

    task automatic test_single();
        bit found;
        wait_valid(found);
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL single_timeout: got %b expected 1", found); end
        n_cmp++; if (insn_opcode !== 8'h03) begin n_err++; $display("FAIL single_opcode: got %h expected 03", insn_opcode); end
        n_cmp++; if (insn_len !== 2'd0) begin n_err++; $display("FAIL single_len: got %0d expected 0", insn_len); end
        n_cmp++; if (insn_operand !== 16'h0000) begin n_err++; $display("FAIL single_operand: got %h expected 0000", insn_operand); end
        n_cmp++; if (insn_pc !== 8'h10) begin n_err++; $display("FAIL single_pc: got %h expected 10", insn_pc); end
        n_cmp++; if (fetch_start !== 1'b0) begin n_err++; $display("FAIL emit_no_fetch: got %b expected 0", fetch_start); end
    endtask

    task automatic test_sipush();
        bit found;
        wait_valid(found);
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL sipush_timeout: got %b expected 1", found); end
        n_cmp++; if (insn_opcode !== 8'h11) begin n_err++; $display("FAIL sipush_opcode: got %h expected 11", insn_opcode); end
        n_cmp++; if (insn_len !== 2'd2) begin n_err++; $display("FAIL sipush_len: got %0d expected 2", insn_len); end
        n_cmp++; if (insn_operand !== 16'h1234) begin n_err++; $display("FAIL sipush_operand: got %h expected 1234", insn_operand); end
        n_cmp++; if (insn_pc !== 8'h11) begin n_err++; $display("FAIL sipush_pc: got %h expected 11", insn_pc); end
    endtask

    task automatic test_stall();
        bit found;
        found = 1'b0;
        @(negedge clk);
        insn_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            fetch_ready = ~fetch_ready;
            @(negedge clk);
            if (insn_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        fetch_ready = 1'b1;
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL stall_timeout: got %b expected 1", found); end
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (insn_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b expected 1", c, insn_valid); end
            n_cmp++; if ({insn_opcode, insn_operand, insn_len, insn_pc} !== {8'h10, 16'h0080, 2'd1, 8'h14})
                begin n_err++; $display("FAIL stall_insn[%0d]: got %h expected %h", c, {insn_opcode, insn_operand, insn_len, insn_pc}, {8'h10, 16'h0080, 2'd1, 8'h14}); end
            n_cmp++; if (fetch_start !== 1'b0) begin n_err++; $display("FAIL stall_no_prefetch[%0d]: got %b expected 0", c, fetch_start); end
            @(negedge clk);
        end
        insn_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (insn_valid !== 1'b0) begin n_err++; $display("FAIL stall_release_valid: got %b expected 0", insn_valid); end
        n_cmp++; if (fetch_start !== 1'b1) begin n_err++; $display("FAIL stall_release_start: got %b expected 1", fetch_start); end
    endtask

    task automatic test_redirect();
        bit found;
        @(negedge clk);
        n_cmp++; if (fetch_start !== 1'b1) begin n_err++; $display("FAIL goto_opnd1_start: got %b expected 1", fetch_start); end
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++; if (fetch_pc_load_n !== 1'b0) begin n_err++; $display("FAIL redir_load_n: got %b expected 0", fetch_pc_load_n); end
        n_cmp++; if (fetch_pc_value !== 8'h40) begin n_err++; $display("FAIL redir_value: got %h expected 40", fetch_pc_value); end
        n_cmp++; if (insn_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid: got %b expected 0", insn_valid); end
        wait_valid(found);
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL redir_timeout: got %b expected 1", found); end
        n_cmp++; if (insn_pc !== 8'h40) begin n_err++; $display("FAIL redir_next_pc: got %h expected 40", insn_pc); end
        n_cmp++; if (insn_opcode !== 8'h00) begin n_err++; $display("FAIL redir_next_opcode: got %h expected 00", insn_opcode); end
    endtask

    task automatic test_wrap();
        bit found;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++; if (fetch_pc_value !== 8'hFE) begin n_err++; $display("FAIL wrap_load_value: got %h expected fe", fetch_pc_value); end
        wait_valid(found);
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL wrap_timeout: got %b expected 1", found); end
        n_cmp++; if ({insn_opcode, insn_operand, insn_len, insn_pc} !== {8'h11, 16'hABCD, 2'd2, 8'hFE})
            begin n_err++; $display("FAIL wrap_sipush: got %h expected %h", {insn_opcode, insn_operand, insn_len, insn_pc}, {8'h11, 16'hABCD, 2'd2, 8'hFE}); end
        wait_valid(found);
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL wrap_next_timeout: got %b expected 1", found); end
        n_cmp++; if ({insn_opcode, insn_operand, insn_len, insn_pc} !== {8'h15, 16'h0007, 2'd1, 8'h01})
            begin n_err++; $display("FAIL wrap_next_iload: got %h expected %h", {insn_opcode, insn_operand, insn_len, insn_pc}, {8'h15, 16'h0007, 2'd1, 8'h01}); end
    endtask

    task automatic test_emit_redirect();
        bit found;
        @(negedge clk);
        insn_ready = 1'b0;
        wait_valid(found);
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL emit_redir_timeout: got %b expected 1", found); end
        n_cmp++; if (insn_pc !== 8'h03) begin n_err++; $display("FAIL emit_redir_pc: got %h expected 03", insn_pc); end
        insn_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h20;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++; if (insn_valid !== 1'b0) begin n_err++; $display("FAIL emit_redir_valid: got %b expected 0", insn_valid); end
        n_cmp++; if ({fetch_pc_load_n, fetch_pc_value} !== {1'b0, 8'h20}) begin n_err++; $display("FAIL emit_redir_load: got %h expected 020", {fetch_pc_load_n, fetch_pc_value}); end
        wait_valid(found);
        n_cmp++; if ({insn_opcode, insn_operand, insn_len, insn_pc} !== {8'h12, 16'h0055, 2'd1, 8'h20})
            begin n_err++; $display("FAIL emit_redir_ldc: got %h expected %h", {insn_opcode, insn_operand, insn_len, insn_pc}, {8'h12, 16'h0055, 2'd1, 8'h20}); end
    endtask

    task automatic test_async_reset();
        bit found;
        repeat (2) @(negedge clk);
        #2;
        pc_reset = 1'b0;
        #1;
        n_cmp++; if ({insn_valid, fetch_start, fetch_pc_load_n} !== 3'b000) begin n_err++; $display("FAIL arst_ctrl: got %b expected 000", {insn_valid, fetch_start, fetch_pc_load_n}); end
        n_cmp++; if (fetch_pc_value !== 8'h10) begin n_err++; $display("FAIL arst_pc_value: got %h expected 10", fetch_pc_value); end
        n_cmp++; if ({insn_opcode, insn_operand, insn_len, insn_pc} !== 34'h0) begin n_err++; $display("FAIL arst_insn: got %h expected 0", {insn_opcode, insn_operand, insn_len, insn_pc}); end
        @(negedge clk);
        pc_reset = 1'b1;
        wait_valid(found);
        n_cmp++; if ({found, insn_opcode, insn_pc} !== {1'b1, 8'h03, 8'h10}) begin n_err++; $display("FAIL arst_restart: got %h expected 10310", {found, insn_opcode, insn_pc}); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[8'h10] = 8'h03;
        mem[8'h11] = 8'h11; mem[8'h12] = 8'h12; mem[8'h13] = 8'h34;
        mem[8'h14] = 8'h10; mem[8'h15] = 8'h80;
        mem[8'h16] = 8'hA7; mem[8'h17] = 8'h00; mem[8'h18] = 8'h05;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'hAB; mem[8'h00] = 8'hCD;
        mem[8'h01] = 8'h15; mem[8'h02] = 8'h07;
        mem[8'h20] = 8'h12; mem[8'h21] = 8'h55;
        mem[8'h22] = 8'h11; mem[8'h23] = 8'h01; mem[8'h24] = 8'h02;
        pc_reset       = 1'b0;
        fetch_ready    = 1'b1;
        insn_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;

        test_reset();
        test_single();
        test_sipush();
        test_stall();
        test_redirect();
        test_wrap();
        test_emit_redirect();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
